// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Purpose:
//   Brings the fabric PLL out of reset and sequences the downstream
//   per-domain resets. The block runs on the free-running reference clock
//   and drives the PLL reset request. It qualifies the PLL lock indication
//   through a 2-flop synchronizer. Once lock has been stable long enough, it
//   releases the domain resets one at a time in ascending order, STAGGER
//   cycles apart. Lock loss, a lock timeout or a software request restarts
//   the sequence.
//
// Ports:
//   clk           in   free-running reference clock (also the PLL refclk)
//   reset_n       in   asynchronous active-low reset
//   pll_locked    in   PLL lock indication, asynchronous to clk
//   sw_reset_req  in   level request to re-sequence, synchronous to clk
//   pll_rst       out  PLL reset request, active high
//   rst_out_n     out  per-domain resets, active low, registered
//   ready         out  high only while every rst_out_n bit is released
//   retry_count   out  saturating count of lock-timeout retries
//
// Optional feature (macro PLL_RESET_SEQ_LOSS_LATCH_EN):
//   lock_lost_clr in   pulse high to clear lock_lost
//   lock_lost     out  sticky flag, set when lock drops after qualification
//                      (set wins over a coincident clear)
module pll_reset_sequencer #(
  parameter int NUM_RESETS     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGGER        = 8,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
  input  logic                  lock_lost_clr,
  output logic                  lock_lost,
`endif
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] rst_out_n,
  output logic                  ready,
  output logic [3:0]            retry_count
);

  // idx runs one past the last bit; that value marks the final stagger period.
  localparam int IDX_W = $clog2(NUM_RESETS + 1);

  // Terminal counts are PARAM-1 and compared with >=, so the counter can
  // never wrap even if a state is entered with an unexpected count.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_DONE     = IDX_W'(NUM_RESETS);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  lk_meta_q, lk_meta_d;
  logic                  lk_q, lk_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_RESETS-1:0] rst_out_n_q, rst_out_n_d;
  logic                  ready_q, ready_d;
  logic [3:0]            retry_q, retry_d;
  logic [NUM_RESETS-1:0] idx_sel;
  logic                  qualified;

  // Lock synchronizer: lk_q is the only lock view the FSM ever uses.
  always_comb begin
    lk_meta_d = pll_locked;
    lk_d      = lk_meta_q;
  end

  // One-hot decode of the bit currently being released.
  for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_sel
    assign idx_sel[gi] = (idx_q == IDX_W'(gi));
  end

  // States in which lock has been qualified and any loss must abort.
  assign qualified = (state_q == S_STABLE) || (state_q == S_RELEASE) ||
                     (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    ready_d     = ready_q;
    retry_d     = retry_q;

    unique case (state_q)
      S_PLL_RST: begin
        // A held software request keeps restarting the reset pulse.
        if (sw_reset_req) begin
          cnt_d = '0;
        end else if (cnt_q >= RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        if (sw_reset_req) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (lk_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (retry_q != 4'hF) begin
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STABLE, S_RELEASE, S_RUN: begin
        if (sw_reset_req || !lk_q) begin
          // No glitch filtering once qualified: any lk low drops everything.
          state_d     = sw_reset_req ? S_PLL_RST : S_WAIT_LOCK;
          cnt_d       = '0;
          rst_out_n_d = '0;
          ready_d     = 1'b0;
        end else if (state_q == S_STABLE) begin
          if (cnt_q >= STABLE_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == S_RELEASE) begin
          if (idx_q == IDX_DONE) begin
            // One full stagger period has elapsed after the last release.
            state_d = S_RUN;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            // Release the selected bit at the start of its stagger period.
            if (cnt_q == '0) begin
              rst_out_n_d = rst_out_n_q | idx_sel;
            end
            if (cnt_q >= STAGGER_LAST) begin
              cnt_d = '0;
              idx_d = idx_q + 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d     = S_PLL_RST;
        cnt_d       = '0;
        rst_out_n_d = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // pll_rst is registered from the next state so it falls on the very edge
  // that leaves PLL_RST.
  always_comb begin
    pll_rst_d = (state_d == S_PLL_RST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      idx_q       <= '0;
      lk_meta_q   <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_out_n_q <= '0;
      ready_q     <= 1'b0;
      retry_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lk_meta_q   <= lk_meta_d;
      lk_q        <= lk_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_n_q <= rst_out_n_d;
      ready_q     <= ready_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_out_n   = rst_out_n_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;

`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
  logic lock_lost_q, lock_lost_d;

  always_comb begin
    lock_lost_d = lock_lost_q;
    if (qualified && !lk_q) begin
      lock_lost_d = 1'b1;
    end else if (lock_lost_clr) begin
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= lock_lost_d;
    end
  end

  assign lock_lost = lock_lost_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer.
// Directed bring-up / loss / glitch / software-request / async-reset /
// lock-timeout scenarios, followed by randomized lock and request traffic.
// Every clock edge is compared against a timeline model that tracks the
// current phase and the number of edges spent in it.
module tb_pll_reset_sequencer;
  localparam int N   = 3;
  localparam int PRC = 16;
  localparam int LTO = 100;
  localparam int LST = 1024;
  localparam int STG = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pll_locked = 1'b0;
  logic         sw_reset_req = 1'b0;
  logic         clr_in = 1'b0;
  logic         pll_rst;
  logic [N-1:0] rst_out_n;
  logic         ready;
  logic [3:0]   retry_count;
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
  logic         lock_lost;
`endif

  pll_reset_sequencer #(
    .NUM_RESETS(N), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO),
    .LOCK_STABLE(LST), .STAGGER(STG), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
    .lock_lost_clr(clr_in),
    .lock_lost(lock_lost),
`endif
    .pll_rst(pll_rst),
    .rst_out_n(rst_out_n),
    .ready(ready),
    .retry_count(retry_count)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Timeline model: phase plus edges elapsed in that phase.
  typedef enum int {M_RST, M_WAIT, M_STAB, M_REL, M_RUN} mode_t;
  mode_t m_mode;
  int    m_t;
  int    m_retries;
  bit    m_lost;
  bit    lk_h1, lk_h2;   // pll_locked as sampled 1 and 2 edges ago

  int    cyc = 0;
  int    ev_pll_fall, ev_pll_rise, ev_ready, ev_drop, rise_cnt;
  int    ev_rise [N];
  int    falls [$];
  logic [N-1:0] prev_rst = '0;
  logic  prev_pll = 1'b1;
  logic  prev_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RST; m_t = 0; m_retries = 0; m_lost = 0;
    lk_h1 = 0; lk_h2 = 0;
  endtask

  task automatic model_edge(input bit lk, input bit req, input bit clr);
    bit set_lost;
    set_lost = 0;
    case (m_mode)
      M_RST: begin
        if (req) m_t = 0;
        else begin
          m_t++;
          if (m_t == PRC) begin m_mode = M_WAIT; m_t = 0; end
        end
      end
      M_WAIT: begin
        if (req) begin m_mode = M_RST; m_t = 0; end
        else if (lk) begin m_mode = M_STAB; m_t = 0; end
        else begin
          m_t++;
          if (m_t == LTO) begin
            m_mode = M_RST; m_t = 0;
            if (m_retries < 15) m_retries++;
          end
        end
      end
      default: begin
        if (!lk) set_lost = 1;
        if (req) begin m_mode = M_RST; m_t = 0; end
        else if (!lk) begin m_mode = M_WAIT; m_t = 0; end
        else begin
          m_t++;
          if (m_mode == M_STAB && m_t == LST) begin m_mode = M_REL; m_t = 0; end
          else if (m_mode == M_REL && m_t == 1 + N * STG) begin m_mode = M_RUN; m_t = 0; end
        end
      end
    endcase
    if (set_lost) m_lost = 1;
    else if (clr) m_lost = 0;
  endtask

  // Bit i is released 1 + i*STG edges after entering the release phase.
  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] r;
    r = '0;
    if (m_mode == M_RUN) r = '1;
    else if (m_mode == M_REL) begin
      for (int i = 0; i < N; i++) if (m_t >= 1 + i * STG) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic compare_all();
    check("pll_rst", pll_rst, (m_mode == M_RST));
    check("rst_out_n", rst_out_n, exp_rst());
    check("ready", ready, (m_mode == M_RUN));
    check("retry_count", retry_count, m_retries);
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
    check("lock_lost", lock_lost, m_lost);
`endif
  endtask

  task automatic tick();
    bit lk_use;
    @(posedge clk);
    cyc++;
    if (!reset_n) model_reset();
    else begin
      lk_use = lk_h2; lk_h2 = lk_h1; lk_h1 = pll_locked;
      model_edge(lk_use, sw_reset_req, clr_in);
    end
    #1;
    compare_all();
    for (int i = 0; i < N; i++)
      if (prev_rst[i] === 1'b0 && rst_out_n[i] === 1'b1) begin ev_rise[i] = cyc; rise_cnt++; end
    if (prev_ready === 1'b0 && ready === 1'b1) ev_ready = cyc;
    if ((|prev_rst) === 1'b1 && rst_out_n === '0) ev_drop = cyc;
    if (prev_pll === 1'b1 && pll_rst === 1'b0) begin ev_pll_fall = cyc; falls.push_back(cyc); end
    if (prev_pll === 1'b0 && pll_rst === 1'b1) ev_pll_rise = cyc;
    prev_rst = rst_out_n; prev_ready = ready; prev_pll = pll_rst;
  endtask

  task automatic clear_events();
    ev_pll_fall = -1; ev_pll_rise = -1; ev_ready = -1; ev_drop = -1; rise_cnt = 0;
    for (int i = 0; i < N; i++) ev_rise[i] = -1;
    falls.delete();
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < bound) begin tick(); n++; end
    check(tag, ready, 1);
  endtask

  // Release timing measured from the edge that first samples pll_locked=1.
  task automatic check_release(input string tag, input int lock_edge);
    check({tag, "_bit0"}, ev_rise[0] - lock_edge, 2 + LST + 1);
    check({tag, "_bit1"}, ev_rise[1] - ev_rise[0], STG);
    check({tag, "_bit2"}, ev_rise[2] - ev_rise[1], STG);
    check({tag, "_ready"}, ev_ready - ev_rise[2], STG);
  endtask

  int rel_cyc, lock_cyc, f_cyc, req_cyc, g_cyc, gl_cyc, n_wait;

  initial begin
    model_reset();
    clear_events();

    // Reset state
    tick(); tick();
    check("reset_pll_rst", pll_rst, 1);
    check("reset_rst_out_n", rst_out_n, 0);
    check("reset_ready", ready, 0);
    check("reset_retry", retry_count, 0);

    // Normal bring-up: lock rises 100 cycles after reset release
    reset_n = 1'b1;
    rel_cyc = cyc;
    repeat (99) tick();
    pll_locked = 1'b1;
    tick();
    lock_cyc = cyc;
    wait_ready("bringup_ready_reached", 1300);
    check("bringup_pll_fall", ev_pll_fall - rel_cyc, PRC);
    check_release("bringup", lock_cyc);

    // Lock loss in RUN, then relock
    clear_events();
    pll_locked = 1'b0;
    tick();
    f_cyc = cyc;
    repeat (3) tick();
    check("loss_drop_edge", ev_drop - f_cyc, 2);
    check("loss_ready", ready, 0);
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
    check("loss_lock_lost_set", lock_lost, 1);
    clr_in = 1'b1; tick(); clr_in = 1'b0;
    check("loss_lock_lost_clr", lock_lost, 0);
`endif
    clear_events();
    pll_locked = 1'b1;
    tick();
    lock_cyc = cyc;
    wait_ready("relock_ready_reached", 1300);
    check_release("relock", lock_cyc);

    // Software request held for 5 cycles in RUN
    clear_events();
    sw_reset_req = 1'b1;
    tick();
    req_cyc = cyc;
    repeat (4) tick();
    sw_reset_req = 1'b0;
    check("sw_drop_edge", ev_drop, req_cyc);
    check("sw_pll_rise_edge", ev_pll_rise, req_cyc);
    n_wait = 0;
    while (pll_rst === 1'b1 && n_wait < 100) begin tick(); n_wait++; end
    // counting restarts on the last of the 5 request edges, then PRC more
    check("sw_pll_fall_edge", ev_pll_fall - req_cyc, 4 + PRC);
    check("sw_retry_unchanged", retry_count, 0);
    wait_ready("sw_ready_reached", 1300);

    // Single-cycle glitch in RUN, then a glitch at count ~500 in STABLE
    clear_events();
    pll_locked = 1'b0;
    tick();
    g_cyc = cyc;
    pll_locked = 1'b1;
    tick();
    clr_in = 1'b1;      // coincides with the lock_lost set edge
    tick();
    clr_in = 1'b0;
    check("glitch_run_drop", ev_drop - g_cyc, 2);
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
    check("glitch_set_wins", lock_lost, 1);
`endif
    rise_cnt = 0;
    while (cyc < g_cyc + 3 + 499) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    gl_cyc = cyc;
    wait_ready("glitch_ready_reached", 1300);
    check("glitch_no_early_release", rise_cnt, N);
    check_release("glitch", gl_cyc);

    // Async reset mid-RELEASE
    clear_events();
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    n_wait = 0;
    while (rst_out_n[0] !== 1'b1 && n_wait < 1300) begin tick(); n_wait++; end
    check("async_reached_release", rst_out_n[0], 1);
    #5 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_pll_rst", pll_rst, 1);
    check("async_rst_out_n", rst_out_n, 0);
    check("async_ready", ready, 0);
    check("async_retry", retry_count, 0);
`ifdef PLL_RESET_SEQ_LOSS_LATCH_EN
    check("async_lock_lost", lock_lost, 0);
`endif

    // Lock never asserted
    pll_locked = 1'b0;
    tick(); tick();
    clear_events();
    reset_n = 1'b1;
    rel_cyc = cyc;
    repeat (17 * (PRC + LTO) + 20) tick();
    check("never_fall_count", falls.size() >= 15, 1);
    if (falls.size() >= 15) begin
      check("never_first_fall", falls[0] - rel_cyc, PRC);
      check("never_period_1", falls[1] - falls[0], PRC + LTO);
      check("never_period_14", falls[14] - falls[13], PRC + LTO);
    end
    check("never_retry_saturated", retry_count, 15);

    // Randomized lock / request traffic from a fresh reset
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1100, 1400) : $urandom_range(1, 200);
      pll_locked = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < len; j++) begin
        sw_reset_req = ($urandom_range(0, 299) == 0);
        clr_in = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    sw_reset_req = 1'b0;
    clr_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
